// File: rtl/hs_link_pkg.sv
// Shared sizing helpers, default parameters and handshake fire conditions for hs_link_fifo.
package hs_link_pkg;

  localparam int unsigned DEF_DATA_W    = 4;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_AF_THRESH = 3;
  localparam int unsigned DEF_CNT_W     = 16;

  // Occupancy width: must represent 0..DEPTH inclusive.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Pointers wrap by natural overflow, so DEPTH must be a power of two.
  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic logic wr_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

  function automatic logic rd_fire(input logic valid, input logic ready, input logic busy);
    return valid & ready & ~busy;
  endfunction

endpackage

// File: rtl/hs_link_fifo_mem.sv
// Storage for hs_link_fifo: DEPTH x DATA_W register array, one write port, async read.
module hs_link_mem
  import hs_link_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [ptr_w(DEPTH)-1:0]  i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [ptr_w(DEPTH)-1:0]  i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hs_link_fifo.sv
// First-word-fall-through valid/ready link FIFO with busy back-pressure, level, almost-full
// flag and a delivered-word counter.
module hs_link_fifo
  import hs_link_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEF_AF_THRESH,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  input  logic [DATA_W-1:0]           s_data,
  output logic                        s_ready,
  output logic                        m_valid,
  output logic [DATA_W-1:0]           m_data,
  input  logic                        m_ready,
  input  logic                        busy,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic                        almost_full,
  output logic [CNT_W-1:0]            xfer_cnt
);

  localparam int unsigned LVL_W = lvl_w(DEPTH);
  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THRESH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("hs_link_fifo: DEPTH must be a power of two and at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("hs_link_fifo: AF_THRESH must lie in 1..DEPTH");
  end

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [CNT_W-1:0] r_xfer_cnt;
  logic             w_wr_fire;
  logic             w_rd_fire;

  // Flags come from registered state only; s_ready is also held low while in reset.
  assign s_ready     = ~rst & (r_level != LVL_FULL);
  assign m_valid     = (r_level != '0);
  assign almost_full = (r_level >= LVL_AF);
  assign level       = r_level;
  assign xfer_cnt    = r_xfer_cnt;

  assign w_wr_fire = wr_fire(s_valid, s_ready);
  assign w_rd_fire = rd_fire(m_valid, m_ready, busy) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_fire) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
      end
      if (w_wr_fire && !w_rd_fire)      r_level <= r_level + LVL_W'(1);
      else if (!w_wr_fire && w_rd_fire) r_level <= r_level - LVL_W'(1);
    end
  end

  hs_link_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_wr_fire),
    .i_waddr (r_wr_ptr),
    .i_wdata (s_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (m_data)
  );

endmodule

// File: tb/tb_hs_link_fifo.sv
// Self-checking bench for hs_link_fifo: directed scenarios on a 4x4 instance and a random
// valid/ready/busy/reset soak on an 8x8 instance, each tracked by a reference queue.
module tb_hs_link_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: defaults (DATA_W=4, DEPTH=4, AF_THRESH=3, CNT_W=16)
  logic        a_rst, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_busy, a_af;
  logic [3:0]  a_s_data, a_m_data;
  logic [2:0]  a_level;
  logic [15:0] a_cnt;
  logic [3:0]  qa[$];
  int unsigned cnt_a = 0;

  // Instance B: DATA_W=8, DEPTH=8, AF_THRESH=6, CNT_W=8 so the counter wraps
  logic        b_rst, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_busy, b_af;
  logic [7:0]  b_s_data, b_m_data;
  logic [3:0]  b_level;
  logic [7:0]  b_cnt;
  logic [7:0]  qb[$];
  int unsigned cnt_b = 0;

  hs_link_fifo u_dut_a (
    .clk(clk), .rst(a_rst), .s_valid(a_s_valid), .s_data(a_s_data), .s_ready(a_s_ready),
    .m_valid(a_m_valid), .m_data(a_m_data), .m_ready(a_m_ready), .busy(a_busy),
    .level(a_level), .almost_full(a_af), .xfer_cnt(a_cnt)
  );

  hs_link_fifo #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(b_rst), .s_valid(b_s_valid), .s_data(b_s_data), .s_ready(b_s_ready),
    .m_valid(b_m_valid), .m_data(b_m_data), .m_ready(b_m_ready), .busy(b_busy),
    .level(b_level), .almost_full(b_af), .xfer_cnt(b_cnt)
  );

  // Advance one edge on A and apply the same edge to the reference queue; returns at negedge.
  task automatic tick_a();
    bit wr, rd;
    logic [3:0] tmp;
    wr = a_s_valid && !a_rst && (qa.size() != 4);
    rd = (qa.size() != 0) && a_m_ready && !a_busy && !a_rst;
    @(posedge clk);
    if (a_rst) begin
      qa.delete();
      cnt_a = 0;
    end else begin
      if (rd) begin tmp = qa.pop_front(); cnt_a++; end
      if (wr) qa.push_back(a_s_data);
    end
    @(negedge clk);
  endtask

  task automatic tick_b();
    bit wr, rd;
    logic [7:0] tmp;
    wr = b_s_valid && !b_rst && (qb.size() != 8);
    rd = (qb.size() != 0) && b_m_ready && !b_busy && !b_rst;
    @(posedge clk);
    if (b_rst) begin
      qb.delete();
      cnt_b = 0;
    end else begin
      if (rd) begin tmp = qb.pop_front(); cnt_b++; end
      if (wr) qb.push_back(b_s_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_rst = 1'b1; a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b0; a_busy = 1'b0;
    tick_a(); tick_a();
    n_vec++; if (a_s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b exp 0", a_s_ready); end
    n_vec++; if (a_m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b exp 0", a_m_valid); end
    n_vec++; if (a_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d exp 0", a_level); end
    n_vec++; if (a_af !== 1'b0) begin n_err++; $display("FAIL reset_af: got %b exp 0", a_af); end
    n_vec++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL reset_xfer: got %0d exp 0", a_cnt); end
    a_rst = 1'b0; #1;
    n_vec++; if (a_s_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_s_ready: got %b exp 1", a_s_ready); end
  endtask

  task automatic test_single();
    a_s_valid = 1'b1; a_s_data = 4'hA; a_m_ready = 1'b1; a_busy = 1'b0; #1;
    n_vec++; if (a_m_valid !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got %b exp 0", a_m_valid); end
    tick_a();
    a_s_valid = 1'b0; #1;
    n_vec++; if (a_m_valid !== 1'b1) begin n_err++; $display("FAIL single_m_valid: got %b exp 1", a_m_valid); end
    n_vec++; if (a_m_data !== 4'hA) begin n_err++; $display("FAIL single_m_data: got %h exp a", a_m_data); end
    n_vec++; if (a_level !== 3'd1) begin n_err++; $display("FAIL single_level1: got %0d exp 1", a_level); end
    tick_a();
    n_vec++; if (a_level !== 3'd0) begin n_err++; $display("FAIL single_level0: got %0d exp 0", a_level); end
    n_vec++; if (a_cnt !== 16'(cnt_a) || cnt_a != 1) begin n_err++; $display("FAIL single_xfer: got %0d exp 1", a_cnt); end
  endtask

  task automatic test_fill();
    a_m_ready = 1'b0; a_busy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      a_s_valid = 1'b1; a_s_data = 4'(i);
      tick_a();
      n_vec++; if (a_level !== 3'(i)) begin n_err++; $display("FAIL fill_level: got %0d exp %0d", a_level, i); end
      n_vec++; if (a_af !== (i >= 3)) begin n_err++; $display("FAIL fill_af at %0d: got %b exp %b", i, a_af, (i >= 3)); end
    end
    a_s_data = 4'h5; #1;
    n_vec++; if (a_s_ready !== 1'b0) begin n_err++; $display("FAIL full_s_ready: got %b exp 0", a_s_ready); end
    tick_a();
    n_vec++; if (a_level !== 3'd4) begin n_err++; $display("FAIL full_no_accept: got %0d exp 4", a_level); end
    a_s_valid = 1'b0; a_m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_vec++; if (a_m_valid !== 1'b1 || a_m_data !== 4'(i)) begin n_err++; $display("FAIL fill_drain: got v=%b d=%h exp v=1 d=%h", a_m_valid, a_m_data, 4'(i)); end
      tick_a();
    end
    n_vec++; if (a_level !== 3'd0 || a_m_valid !== 1'b0) begin n_err++; $display("FAIL fill_empty: got level %0d v=%b exp 0/0", a_level, a_m_valid); end
  endtask

  task automatic test_full_read();
    logic [3:0] exp [4];
    exp[0] = 4'h7; exp[1] = 4'h8; exp[2] = 4'h9; exp[3] = 4'hE;
    a_m_ready = 1'b0; a_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_s_valid = 1'b1; a_s_data = 4'(6 + i); tick_a();
    end
    a_s_data = 4'hE; a_m_ready = 1'b1; #1;
    n_vec++; if (a_s_ready !== 1'b0) begin n_err++; $display("FAIL fullrd_s_ready: got %b exp 0", a_s_ready); end
    tick_a();
    n_vec++; if (a_level !== 3'd3) begin n_err++; $display("FAIL fullrd_level3: got %0d exp 3", a_level); end
    n_vec++; if (a_s_ready !== 1'b1) begin n_err++; $display("FAIL fullrd_s_ready_next: got %b exp 1", a_s_ready); end
    a_m_ready = 1'b0; tick_a();
    n_vec++; if (a_level !== 3'd4) begin n_err++; $display("FAIL fullrd_level4: got %0d exp 4", a_level); end
    a_s_valid = 1'b0; a_m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (a_m_data !== exp[i]) begin n_err++; $display("FAIL fullrd_order %0d: got %h exp %h", i, a_m_data, exp[i]); end
      tick_a();
    end
  endtask

  task automatic test_busy();
    int unsigned c0;
    a_s_valid = 1'b1; a_s_data = 4'h5; a_m_ready = 1'b0; a_busy = 1'b0;
    tick_a();
    a_s_valid = 1'b0; a_m_ready = 1'b1; a_busy = 1'b1; c0 = cnt_a;
    repeat (3) begin
      tick_a();
      n_vec++; if (a_m_valid !== 1'b1 || a_m_data !== 4'h5) begin n_err++; $display("FAIL busy_hold: got v=%b d=%h exp v=1 d=5", a_m_valid, a_m_data); end
      n_vec++; if (a_cnt !== 16'(c0)) begin n_err++; $display("FAIL busy_xfer: got %0d exp %0d", a_cnt, c0); end
    end
    a_busy = 1'b0; tick_a();
    n_vec++; if (a_cnt !== 16'(c0 + 1)) begin n_err++; $display("FAIL busy_release_xfer: got %0d exp %0d", a_cnt, c0 + 1); end
    n_vec++; if (a_level !== 3'd0) begin n_err++; $display("FAIL busy_release_level: got %0d exp 0", a_level); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] d, e;
    d = 4'd1; e = 4'd1;
    a_m_ready = 1'b0; a_busy = 1'b0;
    repeat (2) begin a_s_valid = 1'b1; a_s_data = d; d++; tick_a(); end
    a_m_ready = 1'b1;
    repeat (10) begin
      a_s_data = d; d++; #1;
      n_vec++; if (a_m_data !== e || a_m_data !== qa[0]) begin n_err++; $display("FAIL b2b_order: got %h exp %h", a_m_data, e); end
      n_vec++; if (a_level !== 3'd2) begin n_err++; $display("FAIL b2b_level: got %0d exp 2", a_level); end
      e++;
      tick_a();
    end
    a_s_valid = 1'b0;
    repeat (2) begin
      #1;
      n_vec++; if (a_m_data !== e) begin n_err++; $display("FAIL b2b_drain: got %h exp %h", a_m_data, e); end
      e++;
      tick_a();
    end
  endtask

  task automatic test_reset_mid();
    a_m_ready = 1'b0; a_busy = 1'b0;
    for (int i = 1; i <= 3; i++) begin a_s_valid = 1'b1; a_s_data = 4'(i); tick_a(); end
    a_rst = 1'b1; a_s_data = 4'hF; a_m_ready = 1'b1; #1;
    n_vec++; if (a_s_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_s_ready: got %b exp 0", a_s_ready); end
    tick_a();
    n_vec++; if (a_level !== 3'd0 || a_m_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_clear: got level %0d v=%b exp 0/0", a_level, a_m_valid); end
    n_vec++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_xfer: got %0d exp 0", a_cnt); end
    a_rst = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b0; #1;
    n_vec++; if (a_s_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_s_ready_after: got %b exp 1", a_s_ready); end
    a_s_valid = 1'b1; a_s_data = 4'hD; tick_a();
    a_s_valid = 1'b0; #1;
    n_vec++; if (a_m_data !== 4'hD || a_level !== 3'd1) begin n_err++; $display("FAIL rstmid_new_word: got d=%h level %0d exp d=d level 1", a_m_data, a_level); end
    a_m_ready = 1'b1; tick_a();
    n_vec++; if (a_cnt !== 16'd1 || a_m_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_deliver: got cnt %0d v=%b exp 1/0", a_cnt, a_m_valid); end
  endtask

  task automatic test_random();
    b_rst = 1'b1; b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0; b_busy = 1'b0;
    tick_b();
    b_rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      // Phases bias toward filling or draining so both boundaries get exercised.
      b_s_valid = ((c / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      b_s_data  = 8'($urandom);
      b_m_ready = $urandom_range(0, 2) != 0;
      b_busy    = $urandom_range(0, 4) == 0;
      b_rst     = $urandom_range(0, 999) == 0;
      #1;
      n_vec++; if (b_s_ready !== (!b_rst && qb.size() != 8)) begin n_err++; $display("FAIL rnd_s_ready c%0d: got %b exp %b", c, b_s_ready, (!b_rst && qb.size() != 8)); end
      n_vec++; if (b_level !== 4'(qb.size())) begin n_err++; $display("FAIL rnd_level c%0d: got %0d exp %0d", c, b_level, qb.size()); end
      n_vec++; if (b_af !== (qb.size() >= 6)) begin n_err++; $display("FAIL rnd_af c%0d: got %b exp %b", c, b_af, (qb.size() >= 6)); end
      n_vec++; if (b_cnt !== 8'(cnt_b)) begin n_err++; $display("FAIL rnd_xfer c%0d: got %0d exp %0d", c, b_cnt, 8'(cnt_b)); end
      n_vec++; if (b_m_valid !== (qb.size() != 0)) begin n_err++; $display("FAIL rnd_m_valid c%0d: got %b exp %b", c, b_m_valid, (qb.size() != 0)); end
      if (qb.size() != 0) begin
        n_vec++; if (b_m_data !== qb[0]) begin n_err++; $display("FAIL rnd_m_data c%0d: got %h exp %h", c, b_m_data, qb[0]); end
      end
      tick_b();
    end
    b_rst = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b1; b_busy = 1'b0;
    repeat (9) begin
      #1;
      if (qb.size() != 0) begin
        n_vec++; if (b_m_data !== qb[0]) begin n_err++; $display("FAIL rnd_drain: got %h exp %h", b_m_data, qb[0]); end
      end
      tick_b();
    end
    n_vec++; if (b_level !== 4'd0 || b_cnt !== 8'(cnt_b)) begin n_err++; $display("FAIL rnd_final: got level %0d cnt %0d exp 0/%0d", b_level, b_cnt, 8'(cnt_b)); end
  endtask

  initial begin
    b_rst = 1'b1; b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0; b_busy = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_full_read();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
